// File: rtl/ioctl_pkg.sv
// Shared types and constants for the ioctl download path.
package ioctl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STROBE,
    ST_GAP,
    ST_TAIL
  } state_e;

  localparam int IOCTL_AW = 25;

  localparam logic [7:0] IDX_ROM = 8'd0;
  localparam logic [7:0] IDX_MOD = 8'd1;

endpackage

// File: rtl/ioctl_download_tx.sv
// ioctl download transmitter: turns a valid/ready byte stream into paced
// ioctl_wr strobes with a guaranteed gap between rising edges.
module ioctl_download_tx
  import ioctl_pkg::*;
#(
  parameter int WR_GAP = 8,
  parameter int TAIL   = 4,
  parameter int AW     = IOCTL_AW
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          start,
  input  logic [7:0]    index,
  input  logic          s_valid,
  input  logic [7:0]    s_data,
  input  logic          s_last,
  output logic          s_ready,
  output logic          ioctl_download,
  output logic          ioctl_wr,
  output logic [AW-1:0] ioctl_addr,
  output logic [7:0]    ioctl_dout,
  output logic [7:0]    ioctl_index,
  output logic          busy,
  output logic          addr_wrap
);

  localparam int CMAX = (WR_GAP > TAIL) ? WR_GAP : TAIL;
  localparam int CW   = $clog2(CMAX + 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    dout_q, dout_d;
  logic [7:0]    index_q, index_d;
  logic          wrap_q, wrap_d;
  logic          last_q, last_d;
  logic [AW:0]   addr_inc;

  // Extra top bit of the increment is the wrap carry.
  assign addr_inc = {1'b0, addr_q} + {{AW{1'b0}}, 1'b1};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    index_d = index_q;
    wrap_d  = wrap_q;
    last_d  = last_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          index_d = index;
          addr_d  = '0;
          wrap_d  = 1'b0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (s_valid) begin
          dout_d  = s_data;
          last_d  = s_last;
          state_d = ST_STROBE;
        end
      end
      ST_STROBE: begin
        addr_d  = addr_inc[AW-1:0];
        if (addr_inc[AW]) wrap_d = 1'b1;
        // STROBE + GAP + the accept cycle span WR_GAP cycles in total.
        cnt_d   = CW'(WR_GAP - 3);
        state_d = ST_GAP;
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          if (last_q) begin
            cnt_d   = CW'(TAIL - 1);
            state_d = ST_TAIL;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_TAIL: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      dout_q  <= '0;
      index_q <= '0;
      wrap_q  <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      index_q <= index_d;
      wrap_q  <= wrap_d;
      last_q  <= last_d;
    end
  end

  // Outputs decode straight from the state flop so reset clears them at once.
  assign s_ready        = (state_q == ST_LOAD);
  assign ioctl_wr       = (state_q == ST_STROBE);
  assign busy           = (state_q != ST_IDLE);
  assign ioctl_download = busy;
  assign ioctl_addr     = addr_q;
  assign ioctl_dout     = dout_q;
  assign ioctl_index    = index_q;
  assign addr_wrap      = wrap_q;

endmodule

// File: tb/tb_ioctl_download_tx.sv
// Directed bench: a full-width instance and an AW=4 instance share stimulus;
// a negedge monitor logs every strobe and the ioctl_wr invariants.
module tb_ioctl_download_tx;
  import ioctl_pkg::*;

  localparam int WR_GAP = 8;
  localparam int TAIL   = 4;
  localparam int AW     = 25;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    index = '0;
  logic          s_valid = 1'b0;
  logic [7:0]    s_data = '0;
  logic          s_last = 1'b0;

  logic          s_ready, dl, wr, busy, wrap;
  logic [AW-1:0] addr;
  logic [7:0]    dout, idx_o;
  logic          s_ready2, dl2, wr2, busy2, wrap2;
  logic [3:0]    addr2;
  logic [7:0]    dout2, idx_o2;

  ioctl_download_tx #(.WR_GAP(WR_GAP), .TAIL(TAIL), .AW(AW)) dut (
    .clk_sys(clk), .reset_n(rst_n), .start(start), .index(index),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .ioctl_download(dl), .ioctl_wr(wr), .ioctl_addr(addr), .ioctl_dout(dout),
    .ioctl_index(idx_o), .busy(busy), .addr_wrap(wrap)
  );

  ioctl_download_tx #(.WR_GAP(WR_GAP), .TAIL(TAIL), .AW(4)) dut4 (
    .clk_sys(clk), .reset_n(rst_n), .start(start), .index(index),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready2),
    .ioctl_download(dl2), .ioctl_wr(wr2), .ioctl_addr(addr2), .ioctl_dout(dout2),
    .ioctl_index(idx_o2), .busy(busy2), .addr_wrap(wrap2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe log and invariant monitor.
  int          s_cyc[$];
  logic [31:0] s_addr[$];
  logic [7:0]  s_dout[$];
  logic [31:0] s_addr2[$];
  logic        s_wrap2[$];
  int          viol = 0;
  int          fall_n = 0;
  int          fall_cyc = 0;
  logic        wr_prev = 1'b0;
  logic        dl_prev = 1'b0;

  always @(negedge clk) begin
    if (wr) begin
      s_cyc.push_back(cyc);
      s_addr.push_back(32'(addr));
      s_dout.push_back(dout);
      s_addr2.push_back(32'(addr2));
      s_wrap2.push_back(wrap2);
    end
    if (wr && wr_prev) viol <= viol + 1;
    if (wr && !dl)     viol <= viol + 1;
    if (dl_prev && !dl) begin
      fall_n   <= fall_n + 1;
      fall_cyc <= cyc;
    end
    wr_prev <= wr;
    dl_prev <= dl;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] idx);
    start = 1'b1;
    index = idx;
    tick(1);
    start = 1'b0;
  endtask

  // Returns #1 after the accepting edge, i.e. during the STROBE cycle.
  task automatic send_byte(input logic [7:0] d, input logic last);
    int n;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    n = 0;
    while (!s_ready && n < 100) begin
      tick(1);
      n++;
    end
    if (!s_ready) chk("ready_timeout", 32'(s_ready), 32'd1);
    tick(1);
    s_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 200) begin
      tick(1);
      n++;
    end
    if (busy) chk("idle_timeout", 32'(busy), 32'd0);
    tick(1);
  endtask

  int b;
  int fb;

  initial begin
    // Reset held with start and s_valid asserted.
    start = 1'b1; s_valid = 1'b1; s_data = 8'hFF; index = 8'hFF;
    tick(3);
    chk("rst_outs", 32'({s_ready, dl, wr, addr, dout, idx_o, busy, wrap}), 32'd0);
    chk("rst_outs4", 32'({s_ready2, dl2, wr2, addr2, dout2, idx_o2, busy2, wrap2}), 32'd0);
    start = 1'b0; s_valid = 1'b0;
    rst_n = 1'b1;
    tick(4);
    chk("post_rst_busy", 32'({busy, dl, s_ready}), 32'd0);

    // Single byte.
    b = s_cyc.size();
    do_start(IDX_MOD);
    chk("start_dl", 32'(dl), 32'd1);
    send_byte(8'h02, 1'b1);
    wait_idle();
    chk("single_n", 32'(s_cyc.size() - b), 32'd1);
    chk("single_addr", s_addr[b], 32'd0);
    chk("single_dout", 32'(s_dout[b]), 32'h02);
    chk("single_index", 32'(idx_o), 32'h01);
    chk("single_fall", 32'(fall_cyc - s_cyc[b]), 32'(WR_GAP - 1 + TAIL));
    chk("single_final_addr", 32'(addr), 32'd1);

    // Burst of four bytes, s_valid held high.
    b = s_cyc.size();
    do_start(8'h02);
    for (int i = 0; i < 4; i++) send_byte(8'hA0 + 8'(i), i == 3);
    wait_idle();
    chk("burst_n", 32'(s_cyc.size() - b), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("burst_addr", s_addr[b+i], 32'(i));
      chk("burst_dout", 32'(s_dout[b+i]), 32'(8'hA0 + 8'(i)));
      if (i > 0) chk("burst_period", 32'(s_cyc[b+i] - s_cyc[b+i-1]), 32'(WR_GAP));
    end
    chk("burst_final_addr", 32'(addr), 32'd4);

    // Source stall with a stray start mid-transfer.
    b  = s_cyc.size();
    fb = fall_n;
    do_start(8'h03);
    send_byte(8'h10, 1'b0);
    send_byte(8'h11, 1'b0);
    tick(10);
    do_start(8'h05);
    tick(9);
    chk("stall_n", 32'(s_cyc.size() - b), 32'd2);
    chk("stall_dl", 32'(dl), 32'd1);
    chk("stall_index", 32'(idx_o), 32'h03);
    send_byte(8'h12, 1'b1);
    wait_idle();
    chk("stall_n_end", 32'(s_cyc.size() - b), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk("stall_addr", s_addr[b+i], 32'(i));
      chk("stall_dout", 32'(s_dout[b+i]), 32'(8'h10 + 8'(i)));
    end
    chk("stall_gap", 32'(s_cyc[b+2] - s_cyc[b+1] > 20), 32'd1);
    chk("stall_falls", 32'(fall_n - fb), 32'd1);
    chk("stall_index_end", 32'(idx_o), 32'h03);

    // start and s_valid together in IDLE: byte must not be taken.
    b = s_cyc.size();
    start = 1'b1; index = 8'h06; s_valid = 1'b1; s_data = 8'h77; s_last = 1'b1;
    tick(1);
    start = 1'b0; s_valid = 1'b0;
    tick(5);
    chk("same_cyc_nostrobe", 32'(s_cyc.size() - b), 32'd0);
    chk("same_cyc_load", 32'({busy, s_ready}), 32'b11);
    send_byte(8'h55, 1'b1);
    wait_idle();
    chk("same_cyc_n", 32'(s_cyc.size() - b), 32'd1);
    chk("same_cyc_dout", 32'(s_dout[b]), 32'h55);
    chk("same_cyc_addr", s_addr[b], 32'd0);
    chk("same_cyc_index", 32'(idx_o), 32'h06);

    // Address wrap on the AW=4 instance: 17 bytes.
    b = s_cyc.size();
    do_start(IDX_ROM);
    for (int i = 0; i < 17; i++) send_byte(8'(i), i == 16);
    wait_idle();
    chk("wrap_n", 32'(s_cyc.size() - b), 32'd17);
    chk("wrap_16th_addr", s_addr2[b+15], 32'd15);
    chk("wrap_16th_flag", 32'(s_wrap2[b+15]), 32'd0);
    chk("wrap_17th_addr", s_addr2[b+16], 32'd0);
    chk("wrap_17th_flag", 32'(s_wrap2[b+16]), 32'd1);
    chk("wrap_final4", 32'({wrap2, addr2}), 32'h11);
    chk("wrap_full_addr", 32'(addr), 32'd17);
    chk("wrap_full_flag", 32'(wrap), 32'd0);
    chk("wrap_index", 32'(idx_o), 32'(IDX_ROM));

    // Reset pulsed during GAP.
    do_start(8'h09);
    send_byte(8'h33, 1'b0);
    tick(1);
    chk("gap_state", 32'({busy, wr, s_ready}), 32'b100);
    s_valid = 1'b1; s_data = 8'h44;
    #2 rst_n = 1'b0;
    #1;
    chk("gap_rst_outs", 32'({s_ready, dl, wr, addr, dout, idx_o, busy, wrap}), 32'd0);
    b = s_cyc.size();
    tick(2);
    rst_n = 1'b1;
    tick(20);
    chk("gap_rst_nostrobe", 32'(s_cyc.size() - b), 32'd0);
    chk("gap_rst_idle", 32'({busy, dl}), 32'd0);
    s_valid = 1'b0;

    chk("wr_invariants", 32'(viol), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
